// File: rtl/CPU_Definitions.sv
// Shared types and helpers for the paper-tape front-panel loader.
package CPU_Definitions;

  typedef logic [11:0] word;

  typedef enum logic [1:0] {
    FR_DATA,
    FR_ORIGIN,
    FR_LEADER,
    FR_FIELD
  } frame_cls_e;

  typedef enum logic [3:0] {
    S_LEADER,
    S_HIGH,
    S_LOW,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_FINAL,
    S_DONE,
    S_ERROR
  } state_e;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_SETUP,
    PH_PULSE,
    PH_HOLD
  } phase_e;

  // Field frames (11) share bit 7 with leader (10), so they are split out first.
  function automatic frame_cls_e classify(input logic [7:0] f);
    case (f[7:6])
      2'b11:   return FR_FIELD;
      2'b10:   return FR_LEADER;
      2'b01:   return FR_ORIGIN;
      default: return FR_DATA;
    endcase
  endfunction

  function automatic int eff_cyc(input int n);
    return (n < 1) ? 1 : n;
  endfunction

  function automatic int phase_cnt_w(input int a, input int b, input int c);
    int m;
    m = eff_cyc(a);
    if (eff_cyc(b) > m) m = eff_cyc(b);
    if (eff_cyc(c) > m) m = eff_cyc(c);
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/panel_strobe.sv
// Setup / pulse / hold sequencer for one front-panel switch operation.
module panel_strobe
  import CPU_Definitions::*;
#(
  parameter int SETUP_CYC = 10,
  parameter int PULSE_CYC = 10,
  parameter int HOLD_CYC  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        sel_dep,
  input  logic [11:0] value,
  output logic [11:0] sw_out,
  output logic        load_pc,
  output logic        deposit,
  output logic        last,
  output logic        done
);

  localparam int CNT_W = phase_cnt_w(SETUP_CYC, PULSE_CYC, HOLD_CYC);
  localparam logic [CNT_W-1:0] S_LAST = CNT_W'(eff_cyc(SETUP_CYC) - 1);
  localparam logic [CNT_W-1:0] P_LAST = CNT_W'(eff_cyc(PULSE_CYC) - 1);
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(eff_cyc(HOLD_CYC) - 1);

  phase_e           phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [11:0]      val_q, val_d;
  logic             sel_q, sel_d;

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    val_d   = val_q;
    sel_d   = sel_q;
    case (phase_q)
      PH_SETUP: last = (cnt_q == S_LAST);
      PH_PULSE: last = (cnt_q == P_LAST);
      PH_HOLD:  last = (cnt_q == H_LAST);
      default:  last = 1'b0;
    endcase
    if (start) begin
      phase_d = PH_SETUP;
      cnt_d   = '0;
      val_d   = value;
      sel_d   = sel_dep;
    end else if (phase_q != PH_IDLE) begin
      if (last) begin
        cnt_d = '0;
        case (phase_q)
          PH_SETUP: phase_d = PH_PULSE;
          PH_PULSE: phase_d = PH_HOLD;
          default:  phase_d = PH_IDLE;
        endcase
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= PH_IDLE;
      cnt_q   <= '0;
      val_q   <= '0;
      sel_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      val_q   <= val_d;
      sel_q   <= sel_d;
    end
  end

  // Strobes decode straight from flops so reset removes them without waiting for a clock.
  assign done    = (phase_q == PH_HOLD) && last;
  assign sw_out  = val_q;
  assign load_pc = (phase_q == PH_PULSE) && !sel_q;
  assign deposit = (phase_q == PH_PULSE) && sel_q;

endmodule

// File: rtl/panel_loader.sv
// Reads a BIN paper tape frame by frame and replays it as front-panel Load PC / Deposit operations.
module panel_loader
  import CPU_Definitions::*;
#(
  parameter int  SETUP_CYC = 10,
  parameter int  PULSE_CYC = 10,
  parameter int  HOLD_CYC  = 10,
  parameter word START_PC  = 12'o200
) (
  input  logic        clk,
  input  logic        btnCpuReset,
  input  logic [7:0]  frame,
  input  logic        frame_valid,
  output logic        frame_ready,
  output logic [11:0] sw_out,
  output logic        load_pc,
  output logic        deposit,
  output logic        run,
  output logic        busy,
  output logic        done,
  output logic        cksum_err,
  output logic        fmt_err
);

  localparam int CNT_W = phase_cnt_w(SETUP_CYC, PULSE_CYC, HOLD_CYC);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(eff_cyc(SETUP_CYC) - 1);

  state_e           state_q, state_d;
  logic [6:0]       hi_q, hi_d;
  logic             pend_vld_q, pend_vld_d;
  word              pend_val_q, pend_val_d;
  logic [7:0]       pend_hi_q, pend_hi_d;
  logic [7:0]       pend_lo_q, pend_lo_d;
  logic             pend_org_q, pend_org_d;
  word              cksum_q, cksum_d;
  logic             cksum_err_q, cksum_err_d;
  logic             fmt_err_q, fmt_err_d;
  logic             run_q, run_d;
  logic             done_q, done_d;
  logic             rdy_q, rdy_d;
  logic             fin_wait_q, fin_wait_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;

  frame_cls_e cls;
  word        new_word;
  logic       accept;
  logic       strb_start, strb_sel, strb_last, strb_done;
  word        strb_val;

  assign cls      = classify(frame);
  assign new_word = {hi_q[5:0], frame[5:0]};
  assign accept   = frame_valid && frame_ready;
  assign rdy_d    = 1'b1;

  always_comb begin
    state_d     = state_q;
    hi_d        = hi_q;
    pend_vld_d  = pend_vld_q;
    pend_val_d  = pend_val_q;
    pend_hi_d   = pend_hi_q;
    pend_lo_d   = pend_lo_q;
    pend_org_d  = pend_org_q;
    cksum_d     = cksum_q;
    cksum_err_d = cksum_err_q;
    fmt_err_d   = fmt_err_q;
    run_d       = run_q;
    done_d      = done_q;
    fin_wait_d  = fin_wait_q;
    wcnt_d      = wcnt_q;
    strb_start  = 1'b0;
    strb_sel    = 1'b0;
    strb_val    = pend_val_q;
    case (state_q)
      S_LEADER: begin
        if (accept && cls != FR_FIELD && cls != FR_LEADER) begin
          hi_d    = frame[6:0];
          state_d = S_LOW;
        end
      end
      S_HIGH: begin
        if (accept && cls == FR_LEADER) begin
          if (pend_vld_q) begin
            // Trailer: the pending word is the checksum and is only compared, never deposited.
            cksum_err_d = (pend_val_q != cksum_q);
            strb_start  = 1'b1;
            strb_sel    = 1'b0;
            strb_val    = START_PC;
            state_d     = S_FINAL;
          end else begin
            fmt_err_d = 1'b1;
            state_d   = S_ERROR;
          end
        end else if (accept && cls != FR_FIELD) begin
          hi_d    = frame[6:0];
          state_d = S_LOW;
        end
      end
      S_LOW: begin
        if (accept && cls == FR_LEADER) begin
          fmt_err_d = 1'b1;
          state_d   = S_ERROR;
        end else if (accept && cls != FR_FIELD) begin
          if (pend_vld_q) begin
            strb_start = 1'b1;
            strb_sel   = !pend_org_q;
            cksum_d    = cksum_q + {4'b0, pend_hi_q} + {4'b0, pend_lo_q};
            state_d    = S_SETUP;
          end else begin
            state_d = S_HIGH;
          end
          pend_vld_d = 1'b1;
          pend_val_d = new_word;
          pend_hi_d  = {1'b0, hi_q};
          pend_lo_d  = frame;
          pend_org_d = hi_q[6];
        end
      end
      S_SETUP: if (strb_last) state_d = S_PULSE;
      S_PULSE: if (strb_last) state_d = S_HOLD;
      S_HOLD:  if (strb_last) state_d = S_HIGH;
      S_FINAL: begin
        if (!fin_wait_q) begin
          if (strb_done) begin
            fin_wait_d = 1'b1;
            wcnt_d     = '0;
          end
        end else if (wcnt_q == WAIT_LAST) begin
          fin_wait_d = 1'b0;
          run_d      = 1'b1;
          done_d     = 1'b1;
          state_d    = S_DONE;
        end else begin
          wcnt_d = wcnt_q + CNT_W'(1);
        end
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk or negedge btnCpuReset) begin
    if (!btnCpuReset) begin
      state_q     <= S_LEADER;
      hi_q        <= '0;
      pend_vld_q  <= 1'b0;
      pend_val_q  <= '0;
      pend_hi_q   <= '0;
      pend_lo_q   <= '0;
      pend_org_q  <= 1'b0;
      cksum_q     <= '0;
      cksum_err_q <= 1'b0;
      fmt_err_q   <= 1'b0;
      run_q       <= 1'b0;
      done_q      <= 1'b0;
      rdy_q       <= 1'b0;
      fin_wait_q  <= 1'b0;
      wcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      hi_q        <= hi_d;
      pend_vld_q  <= pend_vld_d;
      pend_val_q  <= pend_val_d;
      pend_hi_q   <= pend_hi_d;
      pend_lo_q   <= pend_lo_d;
      pend_org_q  <= pend_org_d;
      cksum_q     <= cksum_d;
      cksum_err_q <= cksum_err_d;
      fmt_err_q   <= fmt_err_d;
      run_q       <= run_d;
      done_q      <= done_d;
      rdy_q       <= rdy_d;
      fin_wait_q  <= fin_wait_d;
      wcnt_q      <= wcnt_d;
    end
  end

  panel_strobe #(
    .SETUP_CYC(SETUP_CYC),
    .PULSE_CYC(PULSE_CYC),
    .HOLD_CYC (HOLD_CYC)
  ) u_strobe (
    .clk    (clk),
    .rst_n  (btnCpuReset),
    .start  (strb_start),
    .sel_dep(strb_sel),
    .value  (strb_val),
    .sw_out (sw_out),
    .load_pc(load_pc),
    .deposit(deposit),
    .last   (strb_last),
    .done   (strb_done)
  );

  // rdy_q keeps the handshake closed during reset and for the first edge after it.
  assign frame_ready = rdy_q && (state_q == S_LEADER || state_q == S_HIGH || state_q == S_LOW);
  assign busy        = rdy_q && !frame_ready && state_q != S_DONE && state_q != S_ERROR;
  assign run         = run_q;
  assign done        = done_q;
  assign cksum_err   = cksum_err_q;
  assign fmt_err     = fmt_err_q;

endmodule

// File: tb/tb_panel_loader.sv
// Randomized tape bench for panel_loader, checked against a tape-level reference model.
module tb_panel_loader;
  import CPU_Definitions::*;

  localparam int SETUP    = 3;
  localparam int PULSE    = 6;
  localparam int HOLD     = 0;
  localparam int HOLD_EFF = 1;
  localparam int BUDGET   = 4000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  frame = '0;
  logic        frame_valid = 1'b0;
  logic        frame_ready, load_pc, deposit, run, busy, done, cksum_err, fmt_err;
  logic [11:0] sw_out;

  panel_loader #(
    .SETUP_CYC(SETUP),
    .PULSE_CYC(PULSE),
    .HOLD_CYC (HOLD)
  ) dut (
    .clk        (clk),
    .btnCpuReset(rst_n),
    .frame      (frame),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .sw_out     (sw_out),
    .load_pc    (load_pc),
    .deposit    (deposit),
    .run        (run),
    .busy       (busy),
    .done       (done),
    .cksum_err  (cksum_err),
    .fmt_err    (fmt_err)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [7:0]  tape[$];
  logic [12:0] exp_ops[$];
  logic [12:0] obs_ops[$];
  int          pulse_lens[$];
  int          run_lens[$];
  int          overlap = 0;
  int          plen = 0;
  int          brun = 0;
  logic        exp_done, exp_ck, exp_fmt;
  int          exp_used;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Observes panel activity: each strobe pulse as {deposit, sw_out}, pulse widths,
  // and the length of every busy stretch that ends by reopening frame_ready.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      plen = 0;
      brun = 0;
    end else begin
      if (load_pc && deposit) overlap++;
      if (load_pc || deposit) begin
        if (plen == 0) obs_ops.push_back({deposit, sw_out});
        plen++;
      end else if (plen > 0) begin
        pulse_lens.push_back(plen);
        plen = 0;
      end
      if (busy) brun++;
      else begin
        if (brun > 0 && frame_ready) run_lens.push_back(brun);
        brun = 0;
      end
    end
  end

  // Reference: walk the tape as words, emit the expected panel operations in order.
  task automatic run_model();
    logic [7:0]  hi, ph, pl, f;
    logic        have_hi, pvld, porg;
    logic [11:0] pv, sum;
    exp_ops.delete();
    exp_done = 1'b0; exp_ck = 1'b0; exp_fmt = 1'b0; exp_used = tape.size();
    hi = '0; ph = '0; pl = '0; have_hi = 1'b0; pvld = 1'b0; porg = 1'b0; pv = '0; sum = '0;
    for (int i = 0; i < tape.size(); i++) begin
      f = tape[i];
      if (f[7:6] == 2'b11) continue;
      if (f[7]) begin
        if (have_hi) begin exp_fmt = 1'b1; exp_used = i + 1; return; end
        if (pvld) begin
          exp_done = 1'b1;
          exp_ck   = (pv != sum);
          exp_ops.push_back({1'b0, 12'o200});
          exp_used = i + 1;
          return;
        end
        continue;
      end
      if (!have_hi) begin hi = f; have_hi = 1'b1; continue; end
      have_hi = 1'b0;
      if (pvld) begin
        exp_ops.push_back({~porg, pv});
        sum = sum + 12'(ph) + 12'(pl);
      end
      pv = {hi[5:0], f[5:0]}; ph = hi; pl = f; porg = hi[6]; pvld = 1'b1;
    end
  endtask

  task automatic gen_tape(input int nwords, input bit good_ck, input int bad_at);
    logic [11:0] sum, v, ck;
    logic [7:0]  hf, lf;
    logic        org;
    tape.delete();
    sum = '0;
    repeat ($urandom_range(1, 3)) tape.push_back(8'o200);
    for (int w = 0; w < nwords; w++) begin
      v   = 12'($urandom);
      org = (w == 0) || ($urandom_range(0, 4) == 0);
      hf  = {1'b0, org, v[11:6]};
      lf  = {2'b00, v[5:0]};
      tape.push_back(hf);
      if (w == bad_at) tape.push_back(8'o200);
      if ($urandom_range(0, 2) == 0) tape.push_back(8'($urandom_range(192, 255)));
      tape.push_back(lf);
      sum = sum + 12'(hf) + 12'(lf);
    end
    ck = good_ck ? sum : (sum ^ 12'(1 << $urandom_range(0, 11)));
    tape.push_back({2'b00, ck[11:6]});
    tape.push_back({2'b00, ck[5:0]});
    tape.push_back(8'o200);
    tape.push_back(8'o200);
  endtask

  task automatic do_reset();
    frame_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic feed(output int n_acc);
    int   cyc;
    logic acc;
    cyc = 0;
    n_acc = 0;
    while (n_acc < tape.size() && !done && !fmt_err && cyc < BUDGET) begin
      if ($urandom_range(0, 3) == 0) frame_valid = 1'b0;
      else begin
        frame_valid = 1'b1;
        frame = tape[n_acc];
      end
      acc = frame_valid && frame_ready;
      @(negedge clk);
      cyc++;
      if (acc) n_acc++;
    end
    frame_valid = 1'b0;
  endtask

  task automatic play(input string tag);
    int n_acc, cyc, n_commit;
    run_model();
    obs_ops.delete(); pulse_lens.delete(); run_lens.delete(); overlap = 0;
    feed(n_acc);
    cyc = 0;
    while (!done && !fmt_err && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
    end
    repeat (2) @(negedge clk);
    n_commit = exp_ops.size() - (exp_done ? 1 : 0);
    check({tag, ".ended"}, 32'(done || fmt_err), 32'(1));
    check({tag, ".consumed"}, 32'(n_acc), 32'(exp_used));
    check({tag, ".done"}, 32'(done), 32'(exp_done));
    check({tag, ".run"}, 32'(run), 32'(exp_done));
    check({tag, ".fmt_err"}, 32'(fmt_err), 32'(exp_fmt));
    check({tag, ".cksum_err"}, 32'(cksum_err), 32'(exp_ck));
    check({tag, ".busy_end"}, 32'(busy), 32'(0));
    check({tag, ".n_ops"}, 32'(obs_ops.size()), 32'(exp_ops.size()));
    for (int k = 0; k < exp_ops.size(); k++)
      if (k < obs_ops.size()) check($sformatf("%s.op%0d", tag, k), 32'(obs_ops[k]), 32'(exp_ops[k]));
    check({tag, ".overlap"}, 32'(overlap), 32'(0));
    check({tag, ".n_busy_runs"}, 32'(run_lens.size()), 32'(n_commit));
    foreach (run_lens[k])
      check($sformatf("%s.busy_len%0d", tag, k), 32'(run_lens[k]), 32'(SETUP + PULSE + HOLD_EFF));
    foreach (pulse_lens[k])
      check($sformatf("%s.pulse_len%0d", tag, k), 32'(pulse_lens[k]), 32'(PULSE));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n_acc, cyc, nw, bad;
    bit good;

    rst_n = 1'b0;
    @(negedge clk);
    check("rst.sw_out", 32'(sw_out), 32'(0));
    check("rst.flags", 32'({load_pc, deposit, run, busy, done, cksum_err, fmt_err, frame_ready}), 32'(0));
    rst_n = 1'b1;
    #1;
    check("rst.ready_held", 32'(frame_ready), 32'(0));
    @(negedge clk);
    check("rst.ready_rise", 32'(frame_ready), 32'(1));
    check("rst.busy_idle", 32'(busy), 32'(0));

    tape = {8'o200, 8'o200, 8'o102, 8'o000, 8'o012, 8'o034, 8'o000, 8'o146, 8'o200};
    play("tape0146");

    // Same words with a checksum word whose value equals the sum of the committed frames.
    tape = {8'o200, 8'o200, 8'o102, 8'o000, 8'o012, 8'o034, 8'o001, 8'o050, 8'o200};
    do_reset();
    play("tape_ck_ok");

    tape = {8'o200, 8'o200, 8'o102, 8'o000, 8'o012, 8'o034, 8'o000, 8'o147, 8'o200};
    do_reset();
    play("tape0147");

    tape = {8'o200, 8'o102, 8'o200};
    do_reset();
    play("fmt_low");

    tape = {8'o200, 8'o200, 8'o102, 8'o000, 8'o012, 8'o300, 8'o034, 8'o001, 8'o050, 8'o200};
    do_reset();
    play("field_mid");

    // Reset in the middle of the deposit pulse.
    tape = {8'o200, 8'o200, 8'o102, 8'o000, 8'o012, 8'o034, 8'o000, 8'o146};
    do_reset();
    feed(n_acc);
    cyc = 0;
    while (!deposit && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("rip.dep_on", 32'(deposit), 32'(1));
    repeat (4) @(negedge clk);
    check("rip.dep_5th", 32'(deposit), 32'(1));
    rst_n = 1'b0;
    #1;
    check("rip.dep_drop", 32'(deposit), 32'(0));
    check("rip.flags", 32'({load_pc, run, busy, done, cksum_err, fmt_err, frame_ready}), 32'(0));
    check("rip.sw_out", 32'(sw_out), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    obs_ops.delete();
    repeat (20) @(negedge clk);
    check("rip.no_resume", 32'(obs_ops.size()), 32'(0));
    check("rip.idle_busy", 32'(busy), 32'(0));
    check("rip.idle_ready", 32'(frame_ready), 32'(1));
    tape = {8'o200, 8'o200, 8'o102, 8'o000, 8'o012, 8'o034, 8'o001, 8'o050, 8'o200};
    play("rip.after");

    for (int r = 0; r < 8; r++) begin
      nw   = int'($urandom_range(1, 8));
      good = 1'($urandom_range(0, 1));
      bad  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, nw - 1)) : -1;
      gen_tape(nw, good, bad);
      do_reset();
      play($sformatf("rnd%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
